// File: rtl/rvfi_order_stamper.sv
// rvfi_order_stamper: RVFI retire stage for a multi-slot commit.
// Compacts valid retirement slots onto the low RVFI channels in slot order,
// stamps each with a gap-free 64-bit rvfi_order, and stops accepting
// retirements once a halting instruction has been emitted.
module rvfi_order_stamper #(
  parameter int unsigned NRET        = 2,
  parameter int unsigned XLEN        = 32,
  parameter logic [63:0] ORDER_START = 64'd0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRET-1:0]      ret_valid,
  input  logic [NRET-1:0]      ret_halt,
  input  logic [32*NRET-1:0]   ret_insn,
  input  logic [XLEN*NRET-1:0] ret_pc_rdata,
  input  logic [XLEN*NRET-1:0] ret_pc_wdata,
  output logic [NRET-1:0]      rvfi_valid,
  output logic [64*NRET-1:0]   rvfi_order,
  output logic [32*NRET-1:0]   rvfi_insn,
  output logic [NRET-1:0]      rvfi_halt,
  output logic [XLEN*NRET-1:0] rvfi_pc_rdata,
  output logic [XLEN*NRET-1:0] rvfi_pc_wdata,
  output logic [63:0]          next_order,
  output logic                 halted,
  output logic                 drop_err
);

  // Wide enough to hold a count of 0..NRET accepted slots.
  localparam int unsigned CW = $clog2(NRET + 1);

  logic [NRET-1:0]      valid_q, valid_d;
  logic [64*NRET-1:0]   order_q, order_d;
  logic [32*NRET-1:0]   insn_q, insn_d;
  logic [NRET-1:0]      halt_q, halt_d;
  logic [XLEN*NRET-1:0] pc_rdata_q, pc_rdata_d;
  logic [XLEN*NRET-1:0] pc_wdata_q, pc_wdata_d;
  logic [63:0]          next_order_q, next_order_d;
  logic                 halted_q, halted_d;
  logic                 drop_err_q, drop_err_d;

  logic [NRET-1:0]      accept;
  logic                 drop;
  logic                 stop_seen;
  logic [CW-1:0]        cnt;

  // Accept valid slots up to and including the lowest valid halting slot;
  // anything valid beyond it (or anything at all once halted) is dropped.
  always_comb begin
    accept    = '0;
    drop      = 1'b0;
    stop_seen = halted_q;
    for (int i = 0; i < NRET; i++) begin
      if (ret_valid[i]) begin
        if (stop_seen) begin
          drop = 1'b1;
        end else begin
          accept[i] = 1'b1;
          if (ret_halt[i]) stop_seen = 1'b1;
        end
      end
    end
  end

  // Compaction: the k-th accepted slot drives channel k with order next+k.
  always_comb begin
    valid_d    = '0;
    order_d    = '0;
    insn_d     = '0;
    halt_d     = '0;
    pc_rdata_d = '0;
    pc_wdata_d = '0;
    cnt        = '0;
    for (int i = 0; i < NRET; i++) begin
      if (accept[i]) begin
        for (int c = 0; c < NRET; c++) begin
          if (cnt == CW'(c)) begin
            valid_d[c]                 = 1'b1;
            order_d[64*c +: 64]        = next_order_q + 64'(unsigned'(c));
            insn_d[32*c +: 32]         = ret_insn[32*i +: 32];
            halt_d[c]                  = ret_halt[i];
            pc_rdata_d[XLEN*c +: XLEN] = ret_pc_rdata[XLEN*i +: XLEN];
            pc_wdata_d[XLEN*c +: XLEN] = ret_pc_wdata[XLEN*i +: XLEN];
          end
        end
        cnt = cnt + CW'(1);
      end
    end
    next_order_d = next_order_q + 64'(cnt);
    halted_d     = halted_q | (|(accept & ret_halt));
    drop_err_d   = drop_err_q | drop;
  end

  // Output register; reset wins over any retirement activity.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      order_q      <= '0;
      insn_q       <= '0;
      halt_q       <= '0;
      pc_rdata_q   <= '0;
      pc_wdata_q   <= '0;
      next_order_q <= ORDER_START;
      halted_q     <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      order_q      <= order_d;
      insn_q       <= insn_d;
      halt_q       <= halt_d;
      pc_rdata_q   <= pc_rdata_d;
      pc_wdata_q   <= pc_wdata_d;
      next_order_q <= next_order_d;
      halted_q     <= halted_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign rvfi_valid    = valid_q;
  assign rvfi_order    = order_q;
  assign rvfi_insn     = insn_q;
  assign rvfi_halt     = halt_q;
  assign rvfi_pc_rdata = pc_rdata_q;
  assign rvfi_pc_wdata = pc_wdata_q;
  assign next_order    = next_order_q;
  assign halted        = halted_q;
  assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_rvfi_order_stamper.sv
// Bench for rvfi_order_stamper: two instances (order start 0 and 2^64-1)
// share the same stimulus and are checked every cycle against a queue-based
// reference model, plus hand-computed literal expectations.
module tb_rvfi_order_stamper;

  localparam int NRET = 2;
  localparam int XLEN = 32;
  localparam logic [63:0] START_A = 64'd0;
  localparam logic [63:0] START_B = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                 clock;
  logic                 reset;
  logic [NRET-1:0]      ret_valid;
  logic [NRET-1:0]      ret_halt;
  logic [32*NRET-1:0]   ret_insn;
  logic [XLEN*NRET-1:0] ret_pc_rdata;
  logic [XLEN*NRET-1:0] ret_pc_wdata;

  logic [NRET-1:0]      a_valid, b_valid, a_halt, b_halt;
  logic [64*NRET-1:0]   a_order, b_order;
  logic [32*NRET-1:0]   a_insn, b_insn;
  logic [XLEN*NRET-1:0] a_pcr, b_pcr, a_pcw, b_pcw;
  logic [63:0]          a_next, b_next;
  logic                 a_halted, b_halted, a_drop, b_drop;

  int checks = 0;
  int errors = 0;

  rvfi_order_stamper #(.NRET(NRET), .XLEN(XLEN), .ORDER_START(START_A)) dut_a (
    .clock(clock), .reset(reset), .ret_valid(ret_valid), .ret_halt(ret_halt),
    .ret_insn(ret_insn), .ret_pc_rdata(ret_pc_rdata), .ret_pc_wdata(ret_pc_wdata),
    .rvfi_valid(a_valid), .rvfi_order(a_order), .rvfi_insn(a_insn), .rvfi_halt(a_halt),
    .rvfi_pc_rdata(a_pcr), .rvfi_pc_wdata(a_pcw), .next_order(a_next),
    .halted(a_halted), .drop_err(a_drop));

  rvfi_order_stamper #(.NRET(NRET), .XLEN(XLEN), .ORDER_START(START_B)) dut_b (
    .clock(clock), .reset(reset), .ret_valid(ret_valid), .ret_halt(ret_halt),
    .ret_insn(ret_insn), .ret_pc_rdata(ret_pc_rdata), .ret_pc_wdata(ret_pc_wdata),
    .rvfi_valid(b_valid), .rvfi_order(b_order), .rvfi_insn(b_insn), .rvfi_halt(b_halt),
    .rvfi_pc_rdata(b_pcr), .rvfi_pc_wdata(b_pcw), .next_order(b_next),
    .halted(b_halted), .drop_err(b_drop));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state, one entry per instance.
  logic [63:0]          m_next   [2];
  logic                 m_halted [2];
  logic                 m_drop   [2];
  logic [NRET-1:0]      e_valid  [2];
  logic [NRET-1:0]      e_halt   [2];
  logic [64*NRET-1:0]   e_order  [2];
  logic [32*NRET-1:0]   e_insn   [2];
  logic [XLEN*NRET-1:0] e_pcr    [2];
  logic [XLEN*NRET-1:0] e_pcw    [2];

  task automatic model_step(input int d, input logic [63:0] start);
    int  acc[$];
    bit  stop;
    bit  dropped;
    e_valid[d] = '0; e_halt[d] = '0; e_order[d] = '0;
    e_insn[d] = '0;  e_pcr[d] = '0;  e_pcw[d] = '0;
    if (reset) begin
      m_next[d] = start; m_halted[d] = 1'b0; m_drop[d] = 1'b0;
    end else begin
      stop = m_halted[d];
      dropped = 1'b0;
      for (int i = 0; i < NRET; i++) begin
        if (ret_valid[i]) begin
          if (stop) dropped = 1'b1;
          else begin
            acc.push_back(i);
            if (ret_halt[i]) stop = 1'b1;
          end
        end
      end
      foreach (acc[k]) begin
        e_valid[d][k]            = 1'b1;
        e_order[d][64*k +: 64]   = m_next[d] + 64'(k);
        e_insn[d][32*k +: 32]    = ret_insn[32*acc[k] +: 32];
        e_halt[d][k]             = ret_halt[acc[k]];
        e_pcr[d][XLEN*k +: XLEN] = ret_pc_rdata[XLEN*acc[k] +: XLEN];
        e_pcw[d][XLEN*k +: XLEN] = ret_pc_wdata[XLEN*acc[k] +: XLEN];
        if (ret_halt[acc[k]]) m_halted[d] = 1'b1;
      end
      m_next[d] = m_next[d] + 64'(acc.size());
      if (dropped) m_drop[d] = 1'b1;
    end
  endtask

  task automatic cmp_dut(input int d, input logic [NRET-1:0] v, input logic [64*NRET-1:0] o,
                         input logic [32*NRET-1:0] ins, input logic [NRET-1:0] h,
                         input logic [XLEN*NRET-1:0] pr, input logic [XLEN*NRET-1:0] pw,
                         input logic [63:0] nx, input logic hd, input logic de);
    string p;
    p = (d == 0) ? "a" : "b";
    chk({p, "_valid"}, 64'(v), 64'(e_valid[d]));
    chk({p, "_halt"}, 64'(h), 64'(e_halt[d]));
    for (int c = 0; c < NRET; c++) begin
      chk($sformatf("%s_order_ch%0d", p, c), o[64*c +: 64], e_order[d][64*c +: 64]);
      chk($sformatf("%s_insn_ch%0d", p, c), 64'(ins[32*c +: 32]), 64'(e_insn[d][32*c +: 32]));
      chk($sformatf("%s_pcr_ch%0d", p, c), 64'(pr[XLEN*c +: XLEN]), 64'(e_pcr[d][XLEN*c +: XLEN]));
      chk($sformatf("%s_pcw_ch%0d", p, c), 64'(pw[XLEN*c +: XLEN]), 64'(e_pcw[d][XLEN*c +: XLEN]));
    end
    chk({p, "_next_order"}, nx, m_next[d]);
    chk({p, "_halted"}, 64'(hd), 64'(m_halted[d]));
    chk({p, "_drop_err"}, 64'(de), 64'(m_drop[d]));
  endtask

  // Model advance on each edge from the stable inputs, compare just after.
  always @(posedge clock) begin
    model_step(0, START_A);
    model_step(1, START_B);
    #1;
    cmp_dut(0, a_valid, a_order, a_insn, a_halt, a_pcr, a_pcw, a_next, a_halted, a_drop);
    cmp_dut(1, b_valid, b_order, b_insn, b_halt, b_pcr, b_pcw, b_next, b_halted, b_drop);
  end

  task automatic cyc(input logic r, input logic [NRET-1:0] v, input logic [NRET-1:0] h);
    @(negedge clock);
    reset        = r;
    ret_valid    = v;
    ret_halt     = h;
    ret_insn     = {$urandom, $urandom};
    ret_pc_rdata = {$urandom, $urandom};
    ret_pc_wdata = {$urandom, $urandom};
    @(posedge clock);
    #2;
  endtask

  initial begin
    logic [63:0] exp_next;
    logic [NRET-1:0] v, h;
    reset = 1'b1; ret_valid = '0; ret_halt = '0;
    ret_insn = '0; ret_pc_rdata = '0; ret_pc_wdata = '0;

    // Reset with activity present: reset wins.
    cyc(1'b1, 2'b11, 2'b00);
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_next_a", a_next, 64'd0);
    chk("rst_next_b", b_next, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_halted", 64'(a_halted), 64'd0);

    // Back-to-back full retirement.
    cyc(1'b0, 2'b11, 2'b00);
    chk("t1_c0_o0", a_order[63:0], 64'd0);
    chk("t1_c0_o1", a_order[127:64], 64'd1);
    chk("t4_b_o0", b_order[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_b_o1", b_order[127:64], 64'd0);
    chk("t4_b_next", b_next, 64'd1);
    cyc(1'b0, 2'b11, 2'b00);
    chk("t1_c1_o0", a_order[63:0], 64'd2);
    chk("t1_c1_o1", a_order[127:64], 64'd3);
    cyc(1'b0, 2'b11, 2'b00);
    chk("t1_c2_o0", a_order[63:0], 64'd4);
    chk("t1_c2_o1", a_order[127:64], 64'd5);
    chk("t1_next", a_next, 64'd6);

    // Only slot 1 valid: compacts onto channel 0.
    @(negedge clock);
    ret_valid = 2'b10; ret_halt = 2'b00;
    ret_insn = {32'h0000_0013, 32'hDEAD_BEEF};
    @(posedge clock);
    #2;
    chk("t2_valid", 64'(a_valid), 64'd1);
    chk("t2_order", a_order[63:0], 64'd6);
    chk("t2_insn", 64'(a_insn[31:0]), 64'h13);
    chk("t2_ch1_insn", 64'(a_insn[63:32]), 64'd0);

    // Random traffic with no halts; order must stay gap-free.
    exp_next = 64'd7;
    for (int n = 0; n < 1000; n++) begin
      v = 2'($urandom);
      exp_next = exp_next + 64'($countones(v));
      cyc(1'b0, v, 2'b00);
    end
    chk("t6_next", a_next, exp_next);

    // Reset mid-run with activity.
    cyc(1'b1, 2'b11, 2'b00);
    chk("t5_valid", 64'(a_valid), 64'd0);
    chk("t5_next", a_next, 64'd0);

    // Halt on slot 0 while slot 1 also valid.
    cyc(1'b0, 2'b11, 2'b01);
    chk("t3_valid", 64'(a_valid), 64'b01);
    chk("t3_halt", 64'(a_halt), 64'b01);
    chk("t3_drop", 64'(a_drop), 64'd1);
    chk("t3_halted", 64'(a_halted), 64'd1);
    chk("t3_next", a_next, 64'd1);
    cyc(1'b0, 2'b01, 2'b00);
    chk("t3_frozen_valid", 64'(a_valid), 64'd0);
    chk("t3_frozen_next", a_next, 64'd1);

    // Mixed random traffic with occasional halts and resets.
    for (int n = 0; n < 400; n++) begin
      v = 2'($urandom);
      h[0] = ($urandom_range(0, 7) == 0);
      h[1] = ($urandom_range(0, 7) == 0);
      cyc(($urandom_range(0, 39) == 0), v, h);
    end

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
